// File: rtl/div_chk_pkg.sv
// Shared definitions for the serial divisibility checker: FSM state
// encoding used by the top level and its helpers.
package div_chk_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t BUSY = 2'd1;
   localparam state_t DONE = 2'd2;

endpackage : div_chk_pkg

// File: rtl/div_by_n_checker_mod_n_step.sv
// One MSB-first remainder step: appends a chunk of operand bits to the
// running remainder and reduces the result modulo the divisor.
module mod_n_step
   import div_chk_pkg::*;
#(
   parameter  int DIVISOR      = 3,
   parameter  int BITS_PER_CYC = 1,
   localparam int REM_W        = $clog2(DIVISOR)
) (
   input  logic [REM_W-1:0]        acc_in,
   input  logic [BITS_PER_CYC-1:0] chunk,
   output logic [REM_W-1:0]        acc_out
);

   localparam int               SUM_W = REM_W + BITS_PER_CYC;
   localparam logic [SUM_W-1:0] DIV_W = SUM_W'(DIVISOR);

   logic [SUM_W-1:0] shifted;

   // acc*2^B + chunk is a plain concatenation; since acc_in < DIVISOR the
   // reduced value always fits back into REM_W bits.
   always_comb begin
      shifted = {acc_in, chunk};
      acc_out = REM_W'(shifted % DIV_W);
   end

endmodule : mod_n_step

// File: rtl/div_by_n_checker.sv
// Serial remainder / divisibility checker for a constant divisor.
// Accepts one operand in IDLE, folds BITS_PER_CYC bits per cycle into the
// remainder MSB-first, then presents rem/div_by_n with a one-cycle strobe.
module div_by_n_checker
   import div_chk_pkg::*;
#(
   parameter  int DATA_W       = 16,
   parameter  int DIVISOR      = 3,
   parameter  int BITS_PER_CYC = 1,
   localparam int REM_W        = $clog2(DIVISOR),
   localparam int NSTEPS       = DATA_W / BITS_PER_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data,
   input  logic              data_vld,
   output logic              data_rdy,
   output logic [REM_W-1:0]  rem,
   output logic              div_by_n,
   output logic              res_vld
);

   localparam int               CNT_W     = $clog2(NSTEPS + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEPS - 1);
   localparam logic [REM_W:0]   DIV_EXT   = (REM_W + 1)'(DIVISOR);

   if (DIVISOR < 2) begin : g_bad_divisor
      $error("div_by_n_checker: DIVISOR must be >= 2");
   end
   if ((BITS_PER_CYC < 1) || (BITS_PER_CYC > DATA_W)) begin : g_bad_bpc
      $error("div_by_n_checker: BITS_PER_CYC must be in 1..DATA_W");
   end
   if ((DATA_W % BITS_PER_CYC) != 0) begin : g_bad_width
      $error("div_by_n_checker: DATA_W must be a multiple of BITS_PER_CYC");
   end

   state_t                  state;
   logic [DATA_W-1:0]       shift_reg;
   logic [REM_W-1:0]        acc;
   logic [REM_W-1:0]        acc_next;
   logic [CNT_W-1:0]        cnt;
   logic [BITS_PER_CYC-1:0] chunk;

   assign chunk = shift_reg[DATA_W-1 -: BITS_PER_CYC];

   mod_n_step #(
      .DIVISOR      (DIVISOR),
      .BITS_PER_CYC (BITS_PER_CYC)
   ) u_step (
      .acc_in  (acc),
      .chunk   (chunk),
      .acc_out (acc_next)
   );

   // Ready is combinational so it drops immediately while reset is held.
   assign data_rdy = (state == IDLE) && !rst;

   // Main FSM: load in IDLE, fixed NSTEPS reduction steps in BUSY, strobe in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         shift_reg <= '0;
         cnt       <= '0;
         rem       <= '0;
         div_by_n  <= 1'b0;
         res_vld   <= 1'b0;
      end else begin
         res_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (data_vld) begin
                  shift_reg <= data;
                  acc       <= '0;
                  cnt       <= '0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               acc       <= acc_next;
               shift_reg <= shift_reg << BITS_PER_CYC;
               cnt       <= cnt + 1'b1;
               if (cnt == LAST_STEP) begin
                  rem      <= acc_next;
                  div_by_n <= (acc_next == '0);
                  res_vld  <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // The running remainder must stay a proper residue while stepping.
   a_acc_lt_div: assert property (@(posedge clk) disable iff (rst)
      (state == BUSY) |-> ({1'b0, acc} < DIV_EXT));

   // The result strobe never lasts longer than one cycle.
   a_res_vld_pulse: assert property (@(posedge clk) disable iff (rst)
      res_vld |=> !res_vld);

endmodule : div_by_n_checker

// File: tb/tb_div_by_n_checker.sv
// Scoreboard bench for div_by_n_checker, four configurations in parallel.
module tb_div_by_n_checker;

   typedef struct {
      int remExp;
      int divExp;
   } exp_t;

   localparam int DIVS [0:3] = '{3, 5, 7, 10};
   localparam int BPCS [0:3] = '{1, 2, 4, 8};

   localparam logic [15:0] WORDS [0:7] = '{16'd9, 16'hFFFF, 16'hFFFE, 16'd0,
                                          16'd1000, 16'd994, 16'd10, 16'd12};
   localparam int REM3  [0:7] = '{0, 0, 2, 0, 1, 1, 1, 0};
   localparam int REM5  [0:7] = '{4, 0, 4, 0, 0, 4, 0, 2};
   localparam int REM7  [0:7] = '{2, 1, 0, 0, 6, 0, 3, 5};
   localparam int REM10 [0:7] = '{9, 5, 4, 0, 0, 4, 0, 2};

   logic clk;
   int   testsRun  = 0;
   int   failCount = 0;

   // Free-running clock shared by every configuration.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int dirRem(int cfg, int idx);
      case (cfg)
         0:       return REM3[idx];
         1:       return REM5[idx];
         2:       return REM7[idx];
         default: return REM10[idx];
      endcase
   endfunction

   task automatic checkOutput(input int cfg, input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         failCount++;
         $display("[TB] FAIL cfg%0d %s: got %0d, expected %0d", cfg, name, actual, expected);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : cfg_blk
      localparam int DIV_G      = DIVS[g];
      localparam int BPC_G      = BPCS[g];
      localparam int REM_W_G    = $clog2(DIV_G);
      localparam int NSTEPS_G   = 16 / BPC_G;
      localparam int PERIOD_G   = NSTEPS_G + 2;
      localparam int RST_STEP_G = (NSTEPS_G > 5) ? 5 : NSTEPS_G - 1;

      logic               rst;
      logic [15:0]        data;
      logic               data_vld;
      logic               data_rdy;
      logic [REM_W_G-1:0] rem;
      logic               div_by_n;
      logic               res_vld;
      logic               blkDone;
      logic               prevVld;
      exp_t               expQ [$];
      int                 inflight;
      int                 cyc;

      div_by_n_checker #(
         .DATA_W       (16),
         .DIVISOR      (DIV_G),
         .BITS_PER_CYC (BPC_G)
      ) dut (
         .clk      (clk),
         .rst      (rst),
         .data     (data),
         .data_vld (data_vld),
         .data_rdy (data_rdy),
         .rem      (rem),
         .div_by_n (div_by_n),
         .res_vld  (res_vld)
      );

      // Offer one word, wait for acceptance, record the expected result.
      task automatic applyStimulus(input logic [15:0] word, input int expRem);
         int waited;
         exp_t e;
         @(posedge clk);
         #1;
         data     = word;
         data_vld = 1'b1;
         waited   = 0;
         @(negedge clk);
         while (!data_rdy && waited < 200) begin
            @(negedge clk);
            waited++;
         end
         if (!data_rdy) begin
            checkOutput(g, "accept_timeout", int'(data_rdy), 1);
         end else begin
            e.remExp = expRem;
            e.divExp = (expRem == 0) ? 1 : 0;
            expQ.push_back(e);
         end
         @(posedge clk);
         #1;
         data_vld = 1'b0;
         data     = ~word;
      endtask

      task automatic waitIdle();
         int waited;
         waited = 0;
         @(negedge clk);
         while (!data_rdy && waited < 200) begin
            @(negedge clk);
            waited++;
         end
         if (!data_rdy) checkOutput(g, "idle_timeout", int'(data_rdy), 1);
      endtask

      // Stimulus: reset, directed words, reset mid-op, held-valid, random words.
      initial begin
         logic [15:0] w;
         int accepts;
         exp_t e;
         blkDone  = 1'b0;
         rst      = 1'b1;
         data     = '0;
         data_vld = 1'b0;
         @(posedge clk);
         @(posedge clk);
         @(negedge clk);
         checkOutput(g, "reset_rem", int'(rem), 0);
         checkOutput(g, "reset_div", int'(div_by_n), 0);
         checkOutput(g, "reset_res_vld", int'(res_vld), 0);
         checkOutput(g, "reset_rdy_low", int'(data_rdy), 0);
         @(posedge clk);
         #1;
         rst = 1'b0;
         @(negedge clk);
         checkOutput(g, "idle_rdy", int'(data_rdy), 1);

         for (int i = 0; i < 6; i++) applyStimulus(WORDS[i], dirRem(g, i));

         applyStimulus(WORDS[6], dirRem(g, 6));
         repeat (RST_STEP_G) @(posedge clk);
         #1;
         rst = 1'b1;
         @(negedge clk);
         checkOutput(g, "rdy_in_rst", int'(data_rdy), 0);
         @(posedge clk);
         #1;
         rst = 1'b0;
         @(negedge clk);
         checkOutput(g, "abort_rem", int'(rem), 0);
         checkOutput(g, "abort_div", int'(div_by_n), 0);
         checkOutput(g, "abort_res_vld", int'(res_vld), 0);
         checkOutput(g, "abort_rdy", int'(data_rdy), 1);
         repeat (NSTEPS_G + 3) @(negedge clk);
         applyStimulus(WORDS[7], dirRem(g, 7));

         waitIdle();
         @(posedge clk);
         #1;
         data_vld = 1'b1;
         accepts  = 0;
         for (int c = 0; c < 3 * PERIOD_G; c++) begin
            data = WORDS[c % 8];
            @(negedge clk);
            if (data_rdy) begin
               e.remExp = dirRem(g, c % 8);
               e.divExp = (e.remExp == 0) ? 1 : 0;
               expQ.push_back(e);
               accepts++;
            end
            @(posedge clk);
            #1;
         end
         data_vld = 1'b0;
         checkOutput(g, "held_vld_accepts", accepts, 3);

         for (int i = 0; i < 1000; i++) begin
            w = 16'($urandom);
            applyStimulus(w, int'(w) % DIV_G);
         end

         waitIdle();
         repeat (NSTEPS_G + 4) @(negedge clk);
         checkOutput(g, "queue_drain", expQ.size(), 0);
         blkDone = 1'b1;
      end

      // Monitor: tracks each accepted op, checks latency, ready, and results.
      initial begin
         exp_t e;
         inflight = 0;
         cyc      = 0;
         prevVld  = 1'b0;
         forever begin
            @(negedge clk);
            if (rst) begin
               expQ.delete();
               inflight = 0;
               prevVld  = 1'b0;
            end else begin
               if (inflight != 0) begin
                  cyc++;
                  checkOutput(g, "rdy_while_busy", int'(data_rdy), 0);
               end
               if (res_vld) begin
                  checkOutput(g, "res_vld_pulse", int'(prevVld), 0);
                  checkOutput(g, "latency", (inflight != 0) ? cyc : -1, NSTEPS_G + 1);
                  if (expQ.size() == 0) begin
                     checkOutput(g, "unexpected_res", expQ.size(), 1);
                  end else begin
                     e = expQ.pop_front();
                     checkOutput(g, "rem", int'(rem), e.remExp);
                     checkOutput(g, "div_by_n", int'(div_by_n), e.divExp);
                  end
                  inflight = 0;
               end else if ((inflight != 0) && (cyc > NSTEPS_G + 1)) begin
                  checkOutput(g, "missing_res", int'(res_vld), 1);
                  inflight = 0;
                  if (expQ.size() > 0) void'(expQ.pop_front());
               end
               prevVld = res_vld;
               if (data_rdy && data_vld) begin
                  inflight = 1;
                  cyc      = 0;
               end
            end
         end
      end
   end

   // Wait for every configuration to finish, bounded, then summarise.
   initial begin
      int waitCyc;
      logic allDone;
      waitCyc = 0;
      allDone = 1'b0;
      while (!allDone && waitCyc < 90000) begin
         @(posedge clk);
         waitCyc++;
         allDone = cfg_blk[0].blkDone && cfg_blk[1].blkDone &&
                   cfg_blk[2].blkDone && cfg_blk[3].blkDone;
      end
      checkOutput(-1, "all_done", int'(allDone), 1);
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule : tb_div_by_n_checker
